// File: rtl/ones_arb_pkg.sv
// -----------------------------------------------------------------------------
// ones_arb_pkg
// Shared types and default sizing for the ones-count arbiter slice.
//   state_t      : two-state job FSM (idle / counting)
//   DEF_N_REQ    : default number of requesters
//   DEF_R1_SIZE  : default operand width
//   DEF_R2_SIZE  : default result width, wide enough to hold R1_SIZE
// -----------------------------------------------------------------------------
package ones_arb_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_R1_SIZE = 8;
    localparam int DEF_R2_SIZE = 4;

endpackage : ones_arb_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: scans the request vector starting at ptr,
// moving upward and wrapping modulo N_REQ, and reports the first requester
// found.
// Ports:
//   req    in  N_REQ  request levels
//   ptr    in  IDW    first index to examine (always < N_REQ)
//   winner out IDW    index of the selected requester (0 when none)
//   any    out 1      at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [IDW-1:0]   winner,
    output logic             any
);

    int idx_s;

    // Masked priority scan; the first hit after ptr wins and later hits are ignored.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx_s  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            // Wrap the scan index without a modulo operator.
            idx_s  = ((int'(ptr) + k) >= N_REQ) ? (int'(ptr) + k - N_REQ)
                                                : (int'(ptr) + k);
            winner = (!any && req[idx_s]) ? IDW'(idx_s) : winner;
            any    = any | req[idx_s];
        end
    end

endmodule : rr_arbiter

// File: rtl/ones_count_arbiter.sv
// -----------------------------------------------------------------------------
// ones_count_arbiter
// Shares one shift/count "count the 1s" datapath among N_REQ requesters.
// A round-robin pick selects a requester in IDLE, its operand is latched and
// shifted left one bit per cycle while the MSBs are accumulated; once the
// shift register is empty the count is published with the requester id.
// Ports:
//   clk       in   1              clock, all logic on posedge
//   rst       in   1              synchronous reset, active-high
//   req       in   N_REQ          per-requester request level
//   req_data  in   N_REQ*R1_SIZE  operands, slice i = req_data[i*R1_SIZE +: R1_SIZE]
//   gnt       out  N_REQ          registered one-hot grant pulse (1 cycle)
//   busy      out  1              a job is in COUNT
//   done      out  1              result-valid pulse (1 cycle)
//   done_id   out  $clog2(N_REQ)  requester owning the value on count
//   count     out  R2_SIZE        ones-count of the granted operand
// -----------------------------------------------------------------------------
module ones_count_arbiter
    import ones_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int R1_SIZE = DEF_R1_SIZE,
    parameter int R2_SIZE = DEF_R2_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*R1_SIZE-1:0] req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N_REQ)-1:0] done_id,
    output logic [R2_SIZE-1:0]       count
);

    localparam int IDW = $clog2(N_REQ);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [IDW-1:0]       ptr_r;
    logic [IDW-1:0]       ptr_nxt_s;
    logic [R1_SIZE-1:0]   r1_r;
    logic [R1_SIZE-1:0]   r1_nxt_s;
    logic [R2_SIZE-1:0]   cnt_r;
    logic [R2_SIZE-1:0]   cnt_nxt_s;
    logic [IDW-1:0]       cur_id_r;
    logic [IDW-1:0]       cur_id_nxt_s;
    logic [N_REQ-1:0]     gnt_r;
    logic [N_REQ-1:0]     gnt_nxt_s;
    logic                 busy_r;
    logic                 busy_nxt_s;
    logic                 done_r;
    logic                 done_nxt_s;
    logic [IDW-1:0]       done_id_r;
    logic [IDW-1:0]       done_id_nxt_s;
    logic [R2_SIZE-1:0]   count_r;
    logic [R2_SIZE-1:0]   count_nxt_s;

    logic [IDW-1:0]       winner_s;
    logic                 any_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_arbiter (
        .req    (req),
        .ptr    (ptr_r),
        .winner (winner_s),
        .any    (any_s)
    );

    // Next-state and datapath decode; every register holds unless overridden.
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        r1_nxt_s      = r1_r;
        cnt_nxt_s     = cnt_r;
        cur_id_nxt_s  = cur_id_r;
        gnt_nxt_s     = {N_REQ{1'b0}};
        busy_nxt_s    = busy_r;
        done_nxt_s    = 1'b0;
        done_id_nxt_s = done_id_r;
        count_nxt_s   = count_r;

        case (state_r)
            S_IDLE: begin
                if (any_s) begin
                    // Operand is captured only here; later req/data changes are ignored.
                    r1_nxt_s     = req_data[int'(winner_s)*R1_SIZE +: R1_SIZE];
                    cnt_nxt_s    = {R2_SIZE{1'b0}};
                    cur_id_nxt_s = winner_s;
                    ptr_nxt_s    = (winner_s == IDW'(N_REQ-1)) ? {IDW{1'b0}}
                                                               : winner_s + IDW'(1'b1);
                    gnt_nxt_s    = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
                    busy_nxt_s   = 1'b1;
                    state_nxt_s  = S_COUNT;
                end else begin
                    state_nxt_s  = S_IDLE;
                end
            end
            S_COUNT: begin
                if (r1_r != {R1_SIZE{1'b0}}) begin
                    // Trailing zeros never reach the MSB, so the loop ends early.
                    r1_nxt_s  = {r1_r[R1_SIZE-2:0], 1'b0};
                    cnt_nxt_s = cnt_r + {{(R2_SIZE-1){1'b0}}, r1_r[R1_SIZE-1]};
                end else begin
                    count_nxt_s   = cnt_r;
                    done_id_nxt_s = cur_id_r;
                    done_nxt_s    = 1'b1;
                    busy_nxt_s    = 1'b0;
                    state_nxt_s   = S_IDLE;
                end
            end
            default: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath, pointer and output registers; reset drops any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r     <= {IDW{1'b0}};
            r1_r      <= {R1_SIZE{1'b0}};
            cnt_r     <= {R2_SIZE{1'b0}};
            cur_id_r  <= {IDW{1'b0}};
            gnt_r     <= {N_REQ{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            done_id_r <= {IDW{1'b0}};
            count_r   <= {R2_SIZE{1'b0}};
        end else begin
            ptr_r     <= ptr_nxt_s;
            r1_r      <= r1_nxt_s;
            cnt_r     <= cnt_nxt_s;
            cur_id_r  <= cur_id_nxt_s;
            gnt_r     <= gnt_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            done_id_r <= done_id_nxt_s;
            count_r   <= count_nxt_s;
        end
    end

    assign gnt     = gnt_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign done_id = done_id_r;
    assign count   = count_r;

endmodule : ones_count_arbiter

// File: tb/tb_ones_count_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ones_count_arbiter
// Directed bench for ones_count_arbiter. Expected grants and results are
// queued when a job is requested and popped by a monitor whenever the DUT
// pulses gnt or done.
// -----------------------------------------------------------------------------
module tb_ones_count_arbiter;

    localparam int N_REQ   = 4;
    localparam int R1_SIZE = 8;
    localparam int R2_SIZE = 4;
    localparam int IDW     = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*R1_SIZE-1:0] req_data;
    logic [N_REQ-1:0]         gnt;
    logic                     busy;
    logic                     done;
    logic [IDW-1:0]           done_id;
    logic [R2_SIZE-1:0]       count;

    typedef struct {
        logic [N_REQ-1:0] onehot;
        bit               b2b;
    } gnt_exp_t;

    typedef struct {
        int id;
        int cnt;
        int lat;
    } done_exp_t;

    gnt_exp_t  gnt_q[$];
    done_exp_t done_q[$];

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int gnt_cyc  = 0;
    int done_cyc = -100;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    // Free-running cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    ones_count_arbiter #(
        .N_REQ   (N_REQ),
        .R1_SIZE (R1_SIZE),
        .R2_SIZE (R2_SIZE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .count    (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_ones(input logic [R1_SIZE-1:0] d);
        int n = 0;
        for (int i = 0; i < R1_SIZE; i++) n += int'(d[i]);
        return n;
    endfunction

    // Cycles from gnt to done: (R1_SIZE - trailing zeros) + 1, or 1 for zero data.
    function automatic int model_lat(input logic [R1_SIZE-1:0] d);
        int tz = 0;
        if (d == '0) return 1;
        while (d[tz] == 1'b0) tz++;
        return R1_SIZE - tz + 1;
    endfunction

    task automatic expect_job(input int id, input logic [R1_SIZE-1:0] d, input bit b2b);
        gnt_exp_t  g;
        done_exp_t r;
        g.onehot = '0;
        g.onehot[id] = 1'b1;
        g.b2b    = b2b;
        r.id     = id;
        r.cnt    = model_ones(d);
        r.lat    = model_lat(d);
        gnt_q.push_back(g);
        done_q.push_back(r);
    endtask

    // Requester behaviour: drop req the cycle after its grant, optionally re-raise it.
    task automatic run(input int n_done, input int reraise_n, input bit drop_all);
        int               seen   = 0;
        int               budget = 0;
        int               rr_n   = reraise_n;
        logic [N_REQ-1:0] pend   = '0;
        while (seen < n_done && budget < 300) begin
            @(negedge clk);
            budget++;
            req  = req | pend;
            pend = '0;
            if (gnt !== '0) begin
                if (drop_all) req = '0;
                else          req = req & ~gnt;
                if (rr_n > 0) begin
                    pend = gnt;
                    rr_n--;
                end
            end
            if (done === 1'b1) seen++;
        end
        chk("run_done_count", 32'(seen), 32'(n_done));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_gnt",  32'(gnt),  32'(0));
        rst = 1'b0;
    endtask

    initial begin
        gnt_exp_t  ge;
        done_exp_t de;
        int        got;

        rst      = 1'b1;
        req      = 4'b1111;
        req_data = {8'h5A, 8'hC3, 8'hFF, 8'h81};

        // 1: reset held two cycles with all requests high
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset_gnt",     32'(gnt),     32'(0));
            chk("reset_busy",    32'(busy),    32'(0));
            chk("reset_done",    32'(done),    32'(0));
            chk("reset_count",   32'(count),   32'(0));
            chk("reset_done_id", 32'(done_id), 32'(0));
        end
        rst    = 1'b0;
        req    = '0;
        mon_en = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    if (gnt !== '0) begin
                        if (gnt_q.size() == 0) begin
                            chk("unexpected_gnt", 32'(gnt), 32'(0));
                        end else begin
                            ge = gnt_q.pop_front();
                            chk("gnt", 32'(gnt), 32'(ge.onehot));
                            chk("busy_at_gnt", 32'(busy), 32'(1));
                            if (ge.b2b) chk("b2b_gnt_cycle", 32'(cyc), 32'(done_cyc + 1));
                            gnt_cyc = cyc;
                        end
                    end
                    if (done !== 1'b0) begin
                        if (done_q.size() == 0) begin
                            chk("unexpected_done", 32'(done), 32'(0));
                        end else begin
                            de = done_q.pop_front();
                            chk("done_id", 32'(done_id), 32'(de.id));
                            chk("count", 32'(count), 32'(de.cnt));
                            chk("latency", 32'(cyc - gnt_cyc), 32'(de.lat));
                            chk("busy_at_done", 32'(busy), 32'(0));
                            done_cyc = cyc;
                        end
                    end
                end
            end
        join_none

        // 2: single requester, data 1011_0000
        @(negedge clk);
        req_data[0*R1_SIZE +: R1_SIZE] = 8'b1011_0000;
        expect_job(0, 8'b1011_0000, 1'b0);
        req = 4'b0001;
        run(1, 0, 1'b0);

        // 3: zero and all-ones operands on requester 1
        repeat (2) @(negedge clk);
        req_data[1*R1_SIZE +: R1_SIZE] = 8'h00;
        expect_job(1, 8'h00, 1'b0);
        req = 4'b0010;
        run(1, 0, 1'b0);
        repeat (2) @(negedge clk);
        req_data[1*R1_SIZE +: R1_SIZE] = 8'hFF;
        expect_job(1, 8'hFF, 1'b0);
        req = 4'b0010;
        run(1, 0, 1'b0);

        // 4: all four requesting from a fresh pointer
        pulse_reset();
        req_data = {8'h0F, 8'h07, 8'h03, 8'h01};
        expect_job(0, 8'h01, 1'b0);
        expect_job(1, 8'h03, 1'b1);
        expect_job(2, 8'h07, 1'b1);
        expect_job(3, 8'h0F, 1'b1);
        @(negedge clk);
        req = 4'b1111;
        run(4, 0, 1'b0);

        // 5: requesters 0 and 2 re-raising after their first grant
        repeat (2) @(negedge clk);
        req_data[0*R1_SIZE +: R1_SIZE] = 8'h80;
        req_data[2*R1_SIZE +: R1_SIZE] = 8'h3C;
        expect_job(0, 8'h80, 1'b0);
        expect_job(2, 8'h3C, 1'b1);
        expect_job(0, 8'h80, 1'b1);
        expect_job(2, 8'h3C, 1'b1);
        req = 4'b0101;
        run(4, 2, 1'b0);

        // 6: reset three cycles into a long job, then a fresh arbitration
        repeat (2) @(negedge clk);
        req_data[3*R1_SIZE +: R1_SIZE] = 8'hFF;
        ge.onehot = 4'b1000;
        ge.b2b    = 1'b0;
        gnt_q.push_back(ge);
        req = 4'b1000;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (gnt !== '0) got = 1;
        end
        chk("abort_job_granted", 32'(got), 32'(1));
        req = '0;
        repeat (2) @(negedge clk);
        pulse_reset();
        repeat (12) @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 32'(0));
        req_data[1*R1_SIZE +: R1_SIZE] = 8'h0F;
        req_data[2*R1_SIZE +: R1_SIZE] = 8'hAA;
        expect_job(1, 8'h0F, 1'b0);
        req = 4'b0110;
        run(1, 0, 1'b1);

        repeat (3) @(negedge clk);
        chk("gnt_queue_empty",  32'(gnt_q.size()),  32'(0));
        chk("done_queue_empty", 32'(done_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ones_count_arbiter
